seq_frame_tx: RTL and testbench

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

---
 rtl/seq_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_seq_frame_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
// seq_frame_tx -- serial frame transmitter.
//
// Accepts a payload on a valid/ready handshake and emits a frame on a
// single serial line: SYNC_WORD (MSB first), payload (MSB first), then an
// optional even-parity bit, followed by GAP idle-zero cycles.
//
// Parameters:
//   PAYLOAD_W  payload bits per frame (1..32)
//   SYNC_W     sync word length in bits (1..8)
//   SYNC_WORD  sync pattern, sent MSB first
//   GAP        idle-zero cycles after each frame (0..15)
//
// Ports:
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   tx_valid    upstream frame request
//   tx_data     payload, captured at handshake
//   parity_en   append even-parity bit, captured at handshake
//   tx_ready    block can accept a frame (state is IDLE)
//   ser_out     serial line, registered
//   ser_en      ser_out carries a frame bit this cycle, registered
//   busy        state is not IDLE
//   frame_done  one-cycle pulse on the last frame bit, registered
module seq_frame_tx #(
  parameter int unsigned          PAYLOAD_W = 8,
  parameter int unsigned          SYNC_W    = 4,
  parameter logic [SYNC_W-1:0]    SYNC_WORD = 4'b1001,
  parameter int unsigned          GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 parity_en,
  output logic                 tx_ready,
  output logic                 ser_out,
  output logic                 ser_en,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam int unsigned MAX_SP = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
  localparam int unsigned MAXW   = (MAX_SP > GAP) ? MAX_SP : GAP;
  localparam int unsigned CW     = (MAXW < 2) ? 1 : $clog2(MAXW + 1);

  logic [2:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [PAYLOAD_W-1:0] data_q, data_n;
  logic                 par_q, par_n;
  logic [SYNC_W-1:0]    sync_sr, sync_sr_n;
  logic [PAYLOAD_W-1:0] data_sr, data_sr_n;
  logic                 out_n, en_n, done_n;
  logic                 frame_end;

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Next-state logic computes the bit that will be on ser_out in the next
  // cycle, so state and the registered outputs always move together and the
  // state register names the phase of the bit currently on the line.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    data_n    = data_q;
    par_n     = par_q;
    sync_sr_n = sync_sr;
    data_sr_n = data_sr;
    out_n     = 1'b0;
    en_n      = 1'b0;
    done_n    = 1'b0;
    frame_end = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_n   = S_SYNC;
          cnt_n     = CW'(SYNC_W - 1);
          data_n    = tx_data;
          par_n     = parity_en;
          data_sr_n = tx_data;
          sync_sr_n = SYNC_WORD << 1;
          out_n     = SYNC_WORD[SYNC_W-1];
          en_n      = 1'b1;
        end
      end

      S_SYNC: begin
        en_n = 1'b1;
        if (cnt == '0) begin
          state_n   = S_DATA;
          cnt_n     = CW'(PAYLOAD_W - 1);
          out_n     = data_sr[PAYLOAD_W-1];
          data_sr_n = data_sr << 1;
          // A one-bit payload makes the first data bit also the last one.
          done_n    = (PAYLOAD_W == 1) && !par_q;
        end else begin
          cnt_n     = cnt - 1'b1;
          out_n     = sync_sr[SYNC_W-1];
          sync_sr_n = sync_sr << 1;
        end
      end

      S_DATA: begin
        if (cnt == '0) begin
          if (par_q) begin
            state_n = S_PAR;
            out_n   = ^data_q;
            en_n    = 1'b1;
            done_n  = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          en_n      = 1'b1;
          cnt_n     = cnt - 1'b1;
          out_n     = data_sr[PAYLOAD_W-1];
          data_sr_n = data_sr << 1;
          done_n    = (cnt == CW'(1)) && !par_q;
        end
      end

      S_PAR: begin
        frame_end = 1'b1;
      end

      S_GAP: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (frame_end) begin
      if (GAP > 0) begin
        state_n = S_GAP;
        cnt_n   = CW'(GAP - 1);
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      sync_sr    <= '0;
      data_sr    <= '0;
      ser_out    <= 1'b0;
      ser_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_q     <= data_n;
      par_q      <= par_n;
      sync_sr    <= sync_sr_n;
      data_sr    <= data_sr_n;
      ser_out    <= out_n;
      ser_en     <= en_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx with default parameters.
module tb_seq_frame_tx;

  localparam int unsigned GAP_C = 2;

  logic       clk;
  logic       rstn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       tx_ready;
  logic       ser_out;
  logic       ser_en;
  logic       busy;
  logic       frame_done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  seq_frame_tx #(
    .PAYLOAD_W (8),
    .SYNC_W    (4),
    .SYNC_WORD (4'b1001),
    .GAP       (GAP_C)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .parity_en  (parity_en),
    .tx_ready   (tx_ready),
    .ser_out    (ser_out),
    .ser_en     (ser_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback 1001 overlapping detector history.
  logic [3:0] hist;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= 4'b0000;
    else       hist <= {hist[2:0], ser_out};
  end

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic [12:0] bits;   // expected frame, right aligned, first bit at len-1
    int unsigned len;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs packed as {ser_out, ser_en, frame_done, busy, tx_ready}.
  function automatic logic [4:0] outs();
    return {ser_out, ser_en, frame_done, busy, tx_ready};
  endfunction

  // Called at a negedge. Handshakes one frame, then scrambles the inputs to
  // show the captured payload is used, and checks every cycle of the frame.
  task automatic send_frame(input string name, input logic [7:0] data, input logic par,
                            input logic [12:0] bits, input int unsigned len);
    int unsigned guard = 0;
    while (!tx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready_wait"}, {31'd0, tx_ready}, 32'd1);
    tx_valid  = 1'b1;
    tx_data   = data;
    parity_en = par;
    @(posedge clk);
    #1;
    tx_valid  = 1'b0;
    tx_data   = ~data;
    parity_en = ~par;
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      check({name, "_bit"}, {27'd0, outs()},
            {27'd0, bits[len-1-k], 1'b1, (k == int'(len) - 1), 1'b1, 1'b0});
    end
    for (int g = 0; g < int'(GAP_C); g++) begin
      @(negedge clk);
      check({name, "_gap"}, {27'd0, outs()}, {27'd0, 5'b00010});
    end
    @(negedge clk);
    check({name, "_idle"}, {27'd0, outs()}, {27'd0, 5'b00001});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [11:0] f1, f2;
  logic [4:0]  expv;
  int unsigned ndet, det_cyc;

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0, bits: 13'b0_1001_1010_0101, len: 12};
    vecs[1] = '{data: 8'h07, par: 1'b1, bits: 13'b1001_0000_0111_1, len: 13};
    vecs[2] = '{data: 8'h00, par: 1'b0, bits: 13'b0_1001_0000_0000, len: 12};
    vecs[3] = '{data: 8'hFF, par: 1'b1, bits: 13'b1001_1111_1111_0, len: 13};
    vecs[4] = '{data: 8'h81, par: 1'b1, bits: 13'b1001_1000_0001_0, len: 13};

    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; parity_en = 1'b0;
    #3;
    check("reset_outs", {27'd0, outs()}, {27'd0, 5'b00001});
    @(negedge clk); @(negedge clk);
    check("reset_outs_clk", {27'd0, outs()}, {27'd0, 5'b00001});
    rstn = 1'b1;

    // First handshake on the first rising edge after reset release; the
    // 8'h00 entry also sees tx_data flip to 8'hFF right after handshake.
    for (int i = 0; i < 5; i++)
      send_frame("tbl", vecs[i].data, vecs[i].par, vecs[i].bits, vecs[i].len);

    // tx_valid held high: two frames at minimum spacing.
    f1 = {4'b1001, 8'h3C};
    f2 = {4'b1001, 8'hC3};
    tx_valid = 1'b1; tx_data = 8'h3C; parity_en = 1'b0;
    @(posedge clk);
    #1 tx_data = 8'hC3;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 16) tx_valid = 1'b0;
      if (c <= 12)      expv = {f1[12-c], 1'b1, (c == 12), 1'b1, 1'b0};
      else if (c <= 14) expv = 5'b00010;
      else if (c == 15) expv = 5'b00001;
      else if (c <= 27) expv = {f2[27-c], 1'b1, (c == 27), 1'b1, 1'b0};
      else if (c <= 29) expv = 5'b00010;
      else              expv = 5'b00001;
      check("b2b", {27'd0, outs()}, {27'd0, expv});
    end

    // Reset during DATA bit 3 (cycle T+8) discards the frame at once.
    tx_valid = 1'b1; tx_data = 8'hA5; parity_en = 1'b0;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check("pre_rst_busy", {27'd0, outs()}, {27'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    rstn = 1'b0;
    #1;
    check("mid_rst", {27'd0, outs()}, {27'd0, 5'b00001});
    @(negedge clk);
    check("mid_rst_hold", {27'd0, outs()}, {27'd0, 5'b00001});
    rstn = 1'b1;
    send_frame("post_rst", 8'h5A, 1'b1, 13'b1001_0101_1010_0, 13);

    // Loopback detector: one detect, registered after the final sync bit.
    ndet = 0; det_cyc = 0;
    tx_valid = 1'b1; tx_data = 8'h00; parity_en = 1'b0;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (hist == 4'b1001) begin
        ndet++;
        det_cyc = c;
      end
    end
    check("det_count", ndet, 32'd1);
    check("det_cycle", det_cyc, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
